// File: rtl/fx_pt_blk_acc.sv
// Fixed-point block accumulator: sums 1..2^CNTW samples per block and
// emits one saturated result per block over a valid/ready handshake.
module fx_pt_blk_acc #(
  parameter int SN   = 1,
  parameter int DIW  = 12,
  parameter int DFW  = 7,
  parameter int CNTW = 2,
  parameter int OIW  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIW+DFW-1:0]   in_data,
  input  logic [CNTW-1:0]      len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OIW+DFW-1:0]   out_data,
  output logic                 out_sat
);

  localparam int DW = DIW + DFW;
  localparam int AW = DIW + CNTW + DFW;
  localparam int OW = OIW + DFW;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    OUT
  } state_t;

  state_t          state;
  logic [AW-1:0]   acc;
  logic [AW-1:0]   ext;
  logic [AW-1:0]   sum;
  logic [CNTW-1:0] cnt;
  logic            sx;
  logic            accept;
  logic            last;
  logic [OW-1:0]   sat_d;
  logic            sat_f;

  assign sx     = (SN != 0) ? in_data[DW-1] : 1'b0;
  assign ext    = {{CNTW{sx}}, in_data};
  assign accept = in_valid & in_ready;
  assign sum    = (state == IDLE) ? ext : acc + ext;
  assign last   = (state == IDLE) ? (len == '0)
                                  : (cnt == CNTW'(1));

  // Result is formed from the sum being registered, so the
  // block's final value is ready on the edge of its last accept.
  generate
    if (OW >= AW) begin : g_wide
      if (OW == AW) begin : g_eq
        assign sat_d = sum;
      end else begin : g_ext
        assign sat_d = {{(OW-AW){(SN != 0) & sum[AW-1]}}, sum};
      end
      assign sat_f = 1'b0;
    end else if (SN != 0) begin : g_sgn
      logic [AW-OW:0] top;
      assign top   = sum[AW-1:OW-1];
      assign sat_f = !((&top) || !(|top));
      assign sat_d = !sat_f     ? sum[OW-1:0] :
                     sum[AW-1]  ? {1'b1, {(OW-1){1'b0}}} :
                                  {1'b0, {(OW-1){1'b1}}};
    end else begin : g_uns
      assign sat_f = |sum[AW-1:OW];
      assign sat_d = sat_f ? '1 : sum[OW-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            cnt <= len;
            acc <= sum;
            if (last) begin
              state     <= OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= sat_d;
              out_sat   <= sat_f;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc <= sum;
            cnt <= cnt - CNTW'(1);
            if (last) begin
              state     <= OUT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= sat_d;
              out_sat   <= sat_f;
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_pt_blk_acc.sv
// Bench for fx_pt_blk_acc: vector table, scoreboard queue and
// hand-written sequences for backpressure, gaps and reset.
module tb_fx_pt_blk_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [18:0] in_data = '0;
  logic [1:0]  len = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [18:0] out_data;
  logic        out_sat;

  int nchk = 0;
  int npass = 0;

  logic [19:0] q[$];
  logic [19:0] e;

  typedef struct {
    string           name;
    logic [1:0]      len;
    logic [3:0][18:0] s;
    logic [18:0]     d;
    logic            sat;
  } vec_t;

  vec_t tv[9];

  fx_pt_blk_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .len       (len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  // Scoreboard: every handshaken result is matched against the queue
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("out_data", {13'b0, out_data}, {13'b0, e[18:0]});
        chk("out_sat", {31'b0, out_sat}, {31'b0, e[19]});
      end
    end
  end

  function automatic vec_t mk(input string nm, input logic [1:0] l,
                              input logic [18:0] a, input logic [18:0] b,
                              input logic [18:0] c, input logic [18:0] d,
                              input logic [18:0] ed, input logic es);
    vec_t v;
    v.name = nm;
    v.len  = l;
    v.s    = {d, c, b, a};
    v.d    = ed;
    v.sat  = es;
    return v;
  endfunction

  task automatic send(input logic [18:0] d, input logic [1:0] l);
    bit took;
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    len      = l;
    do begin
      took = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!took && n < 20);
    if (!took) begin
      nchk++;
      $display("FAIL send_timeout: in_ready=0 required=1");
    end
  endtask

  task automatic run_blk(input vec_t v);
    q.push_back({v.sat, v.d});
    for (int j = 0; j <= int'(v.len); j++) send(v.s[j], v.len);
    in_valid = 1'b0;
    chk({v.name, "_lat"}, {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    chk({v.name, "_idle_valid"}, {31'b0, out_valid}, 32'd0);
    chk({v.name, "_idle_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  logic [18:0] gd[7];
  logic [6:0]  gv;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0] = mk("ones4", 2'd3, 19'h00080, 19'h00080, 19'h00080, 19'h00080,
               19'h00200, 1'b0);
    tv[1] = mk("max4", 2'd3, 19'h3FFFF, 19'h3FFFF, 19'h3FFFF, 19'h3FFFF,
               19'h3FFFF, 1'b1);
    tv[2] = mk("min4", 2'd3, 19'h40000, 19'h40000, 19'h40000, 19'h40000,
               19'h40000, 1'b1);
    tv[3] = mk("single", 2'd0, 19'h7FF80, 19'h0, 19'h0, 19'h0,
               19'h7FF80, 1'b0);
    tv[4] = mk("pos_over1", 2'd1, 19'h10000, 19'h30000, 19'h0, 19'h0,
               19'h3FFFF, 1'b1);
    tv[5] = mk("pos_edge", 2'd1, 19'h3FF00, 19'h000FF, 19'h0, 19'h0,
               19'h3FFFF, 1'b0);
    tv[6] = mk("neg_edge", 2'd2, 19'h40000, 19'h7FFFF, 19'h00001, 19'h0,
               19'h40000, 1'b0);
    tv[7] = mk("neg_over1", 2'd1, 19'h40000, 19'h7FFFF, 19'h0, 19'h0,
               19'h40000, 1'b1);
    tv[8] = mk("mixed", 2'd3, 19'h00100, 19'h7FF00, 19'h00040, 19'h000C0,
               19'h00100, 1'b0);

    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {13'b0, out_data}, 32'd0);
    chk("rst_out_sat", {31'b0, out_sat}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rel_ready_low", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_ready_high", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 9; i++) run_blk(tv[i]);

    // Backpressure: result held while in_valid stays high
    out_ready = 1'b0;
    q.push_back({1'b0, 19'h00200});
    for (int j = 0; j < 4; j++) send(19'h00080, 2'd3);
    in_data = 19'h3FFFF;
    len     = 2'd0;
    chk("bp_valid", {31'b0, out_valid}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_data", {13'b0, out_data}, 32'h00200);
      chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_done_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_done_ready", {31'b0, in_ready}, 32'd1);

    // Gapped input with len changed after the first sample
    gd[0] = 19'h00080; gd[1] = 19'h3FFFF; gd[2] = 19'h3FFFF;
    gd[3] = 19'h00100; gd[4] = 19'h00040; gd[5] = 19'h3FFFF;
    gd[6] = 19'h7FFC0;
    gv = 7'b1011001;
    q.push_back({1'b0, 19'h00180});
    for (int k = 0; k < 7; k++) begin
      in_valid = gv[k];
      in_data  = gd[k];
      len      = (k == 0) ? 2'd3 : 2'd0;
      @(posedge clk);
      #1;
      if (k < 6) chk("gap_early", {31'b0, out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    chk("gap_lat", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Reset mid-block discards the partial sum
    send(19'h00080, 2'd3);
    send(19'h00080, 2'd3);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd0);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_data", {13'b0, out_data}, 32'd0);
    chk("mid_rst_sat", {31'b0, out_sat}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rel_ready", {31'b0, in_ready}, 32'd1);
    run_blk(mk("post_rst", 2'd3, 19'h00080, 19'h00080, 19'h00080,
               19'h00080, 19'h00200, 1'b0));

    // Reset while a result is pending
    out_ready = 1'b0;
    send(19'h3FFFF, 2'd0);
    in_valid = 1'b0;
    chk("out_pend_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("out_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("out_rst_data", {13'b0, out_data}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    run_blk(mk("post_out_rst", 2'd1, 19'h00040, 19'h00040, 19'h0, 19'h0,
               19'h00080, 1'b0));

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drain", q.size(), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
